reg_status_table: RTL and testbench

- Tomasulo register status table (Qi table). Sits directly downstream of the reservation-station CDB mux.
- Records which reservation-station tag will produce each architectural register, and clears that entry when the mux broadcasts the matching tag.
- Provides two read ports so the issue stage can decide, per source operand, between the register-file value and waiting on a tag.

---
 rtl/reg_status_table.sv | 183 ++++++++++++++++++
 tb/tb_reg_status_table.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_status_table.sv
// reg_status_table: Tomasulo register status (Qi) table.
// Each architectural register records whether a reservation station will
// produce it, and which tag that station carries. Entries clear when the
// CDB mux broadcasts a matching tag; two read ports give the issue stage
// a same-cycle view with CDB bypass.
// Optional build macro: RST_BUSY_CNT_EN adds an exact busy-entry counter
// on busy_count; without it busy_count is tied to zero.

// One table entry: busy bit plus producer tag.
module reg_status_entry #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_hit,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             clr_hit,
  output logic             busy,
  output logic [TAG_W-1:0] tag
);

  // Flush beats everything; a same-edge issue beats the CDB clear so the
  // new producer is never lost to a stale broadcast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      tag  <= '0;
    end else if (flush) begin
      busy <= 1'b0;
      tag  <= '0;
    end else if (issue_hit) begin
      busy <= 1'b1;
      tag  <= issue_tag;
    end else if (clr_hit) begin
      busy <= 1'b0;
      tag  <= '0;
    end
  end

endmodule

module reg_status_table #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int TAG_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cdb_enable,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic              rd_busy_a,
  output logic [TAG_W-1:0]  rd_tag_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_busy_b,
  output logic [TAG_W-1:0]  rd_tag_b,
  output logic              cdb_event,
  output logic [ADDR_W:0]   busy_count
);

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
  } rd_rsp_t;

  logic                           cdb_enable_q;
  logic [TAG_W-1:0]               cdb_tag_q;
  logic                           bcast;
  logic [NUM_REGS-1:0]            busy_vec;
  logic [NUM_REGS-1:0]            hit_vec;
  logic [NUM_REGS-1:0]            live_vec;
  logic [NUM_REGS-1:0]            issue_sel;
  logic [NUM_REGS-1:0][TAG_W-1:0] tag_vec;
  rd_rsp_t                        rsp_a;
  rd_rsp_t                        rsp_b;

  // The mux holds out_enable across cycles: only a rising enable or a new
  // tag under a held enable counts as a broadcast.
  assign bcast = cdb_enable & (~cdb_enable_q | (cdb_tag != cdb_tag_q));

  // Previous-cycle CDB samples and the monitor pulse; these keep sampling
  // through a flush so edge detection stays coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_enable_q <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_event    <= 1'b0;
    end else begin
      cdb_enable_q <= cdb_enable;
      cdb_tag_q    <= cdb_tag;
      cdb_event    <= bcast;
    end
  end

  // Per-register entries. Register 0 never accepts an issue, so it stays
  // idle; destinations past NUM_REGS match no entry and are dropped.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_ent
    if (i == 0) begin : g_zero
      assign issue_sel[i] = 1'b0;
    end else begin : g_nz
      assign issue_sel[i] = issue_valid & (issue_dest == ADDR_W'(i));
    end

    assign hit_vec[i]  = bcast & busy_vec[i] & (tag_vec[i] == cdb_tag);
    assign live_vec[i] = busy_vec[i] & ~hit_vec[i];

    reg_status_entry #(.TAG_W(TAG_W)) u_ent (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .issue_hit (issue_sel[i]),
      .issue_tag (issue_tag),
      .clr_hit   (hit_vec[i]),
      .busy      (busy_vec[i]),
      .tag       (tag_vec[i])
    );
  end

  // Read lookup over the bypassed view; unmatched addresses read idle.
  function automatic rd_rsp_t lookup(
    input logic [ADDR_W-1:0]            addr,
    input logic [NUM_REGS-1:0]          live,
    input logic [NUM_REGS-1:0][TAG_W-1:0] tags
  );
    rd_rsp_t r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i) && live[i]) begin
        r.busy = 1'b1;
        r.tag  = tags[i];
      end
    end
    return r;
  endfunction

  // Both read ports see pre-edge state with the current broadcast removed.
  always_comb begin
    rsp_a = lookup(rd_addr_a, live_vec, tag_vec);
    rsp_b = lookup(rd_addr_b, live_vec, tag_vec);
  end

  assign rd_busy_a = rsp_a.busy;
  assign rd_tag_a  = rsp_a.tag;
  assign rd_busy_b = rsp_b.busy;
  assign rd_tag_b  = rsp_b.tag;

`ifdef RST_BUSY_CNT_EN
  logic          cnt_inc;
  logic [ADDR_W:0] cnt_dec;
  logic [ADDR_W:0] cnt_q;

  // An issue adds one only if its entry is idle or is being cleared this
  // edge; every matched clear removes one.
  always_comb begin
    cnt_inc = |(issue_sel & (~busy_vec | hit_vec));
    cnt_dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_dec = cnt_dec + (ADDR_W+1)'(hit_vec[i]);
    end
  end

  // Incremental busy-entry count, zeroed with the table on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + (ADDR_W+1)'(cnt_inc) - cnt_dec;
    end
  end

  assign busy_count = cnt_q;
`else
  assign busy_count = '0;
`endif

endmodule

// File: tb/tb_reg_status_table.sv
// Bench for reg_status_table: directed table, corner sequences, and a
// randomized run against an array-based reference model.
module tb_reg_status_table;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int TAG_W    = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cdb_enable = 1'b0;
  logic [TAG_W-1:0]  cdb_tag = '0;
  logic              issue_valid = 1'b0;
  logic [ADDR_W-1:0] issue_dest = '0;
  logic [TAG_W-1:0]  issue_tag = '0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] rd_addr_a = '0;
  logic              rd_busy_a;
  logic [TAG_W-1:0]  rd_tag_a;
  logic [ADDR_W-1:0] rd_addr_b = '0;
  logic              rd_busy_b;
  logic [TAG_W-1:0]  rd_tag_b;
  logic              cdb_event;
  logic [ADDR_W:0]   busy_count;

  reg_status_table #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .cdb_enable(cdb_enable), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_tag(issue_tag),
    .flush(flush), .rd_addr_a(rd_addr_a), .rd_busy_a(rd_busy_a), .rd_tag_a(rd_tag_a),
    .rd_addr_b(rd_addr_b), .rd_busy_b(rd_busy_b), .rd_tag_b(rd_tag_b),
    .cdb_event(cdb_event), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays of who-produces-what.
  bit m_busy[NUM_REGS];
  int m_tag[NUM_REGS];
  bit m_en_q;
  int m_tag_q;
  bit m_event;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < NUM_REGS; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  function automatic int exp_count();
`ifdef RST_BUSY_CNT_EN
    return m_count();
`else
    return 0;
`endif
  endfunction

  function automatic bit m_bcast();
    return cdb_enable && (!m_en_q || int'(cdb_tag) != m_tag_q);
  endfunction

  function automatic void m_read(input int a, output bit b, output int t);
    b = 1'b0;
    t = 0;
    if (a != 0 && a < NUM_REGS) begin
      b = m_busy[a] && !(m_bcast() && m_tag[a] == int'(cdb_tag));
      t = b ? m_tag[a] : 0;
    end
  endfunction

  function automatic void m_reset();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_busy[r] = 1'b0;
      m_tag[r]  = 0;
    end
    m_en_q = 1'b0; m_tag_q = 0; m_event = 1'b0;
  endfunction

  // Model one rising edge from the currently driven inputs.
  function automatic void m_edge();
    bit bc = m_bcast();
    if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) begin m_busy[r] = 1'b0; m_tag[r] = 0; end
    end else begin
      if (bc)
        for (int r = 0; r < NUM_REGS; r++)
          if (m_busy[r] && m_tag[r] == int'(cdb_tag)) begin m_busy[r] = 1'b0; m_tag[r] = 0; end
      if (issue_valid && issue_dest != 0 && int'(issue_dest) < NUM_REGS) begin
        m_busy[issue_dest] = 1'b1;
        m_tag[issue_dest]  = int'(issue_tag);
      end
    end
    m_event = bc;
    m_en_q  = cdb_enable;
    m_tag_q = int'(cdb_tag);
  endfunction

  task automatic model_check();
    bit b; int t;
    m_read(int'(rd_addr_a), b, t);
    check("mdl_busy_a", 32'(rd_busy_a), int'(b));
    check("mdl_tag_a",  32'(rd_tag_a),  t);
    m_read(int'(rd_addr_b), b, t);
    check("mdl_busy_b", 32'(rd_busy_b), int'(b));
    check("mdl_tag_b",  32'(rd_tag_b),  t);
    check("mdl_event",  32'(cdb_event), int'(m_event));
    check("mdl_count",  32'(busy_count), exp_count());
  endtask

  // Drive one cycle's inputs on the falling edge, then check pre-edge view.
  task automatic drive(input int iv, input int idest, input int itag, input int en,
                       input int ctag, input int fl, input int ra, input int rb);
    @(negedge clk);
    issue_valid = iv[0];
    issue_dest  = ADDR_W'(idest);
    issue_tag   = TAG_W'(itag);
    cdb_enable  = en[0];
    cdb_tag     = TAG_W'(ctag);
    flush       = fl[0];
    rd_addr_a   = ADDR_W'(ra);
    rd_addr_b   = ADDR_W'(rb);
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
  endtask

  typedef struct {
    int iv, idest, itag, en, ctag, fl, ra, rb;
    int ba, ta, bb, tb, ev, cnt;
  } vec_t;

  vec_t tbl[12];
  int   r_en, r_ct;

  initial begin
    // Directed rows from reset; expectations are pre-edge values.
    tbl[0]  = '{1,4,9,  0,0,0,  4,0, 0,0, 0,0,  0,0};
    tbl[1]  = '{0,0,0,  1,9,0,  4,4, 0,0, 0,0,  0,1};
    tbl[2]  = '{0,0,0,  1,9,0,  4,0, 0,0, 0,0,  1,0};
    tbl[3]  = '{1,5,2,  1,9,0,  5,4, 0,0, 0,0,  0,0};
    tbl[4]  = '{1,6,2,  1,9,0,  5,6, 1,2, 0,0,  0,1};
    tbl[5]  = '{0,0,0,  1,2,0,  5,6, 0,0, 0,0,  0,2};
    tbl[6]  = '{0,0,0,  0,0,0,  5,6, 0,0, 0,0,  1,0};
    tbl[7]  = '{1,7,11, 0,0,0,  7,0, 0,0, 0,0,  0,0};
    tbl[8]  = '{1,7,11, 1,11,0, 7,0, 0,0, 0,0,  0,1};
    tbl[9]  = '{0,0,0,  0,0,0,  7,0, 1,11,0,0,  1,1};
    tbl[10] = '{1,0,3,  0,0,0,  0,7, 0,0, 1,11, 0,1};
    tbl[11] = '{0,0,0,  0,0,0,  0,7, 0,0, 1,11, 0,1};

    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy_a", 32'(rd_busy_a), 0);
    check("rst_tag_a",  32'(rd_tag_a), 0);
    check("rst_event",  32'(cdb_event), 0);
    check("rst_count",  32'(busy_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].iv, tbl[i].idest, tbl[i].itag, tbl[i].en, tbl[i].ctag, tbl[i].fl,
            tbl[i].ra, tbl[i].rb);
      check($sformatf("tbl%0d_busy_a", i), 32'(rd_busy_a), tbl[i].ba);
      check($sformatf("tbl%0d_tag_a", i),  32'(rd_tag_a),  tbl[i].ta);
      check($sformatf("tbl%0d_busy_b", i), 32'(rd_busy_b), tbl[i].bb);
      check($sformatf("tbl%0d_tag_b", i),  32'(rd_tag_b),  tbl[i].tb);
      check($sformatf("tbl%0d_event", i),  32'(cdb_event), tbl[i].ev);
`ifdef RST_BUSY_CNT_EN
      check($sformatf("tbl%0d_count", i),  32'(busy_count), tbl[i].cnt);
`else
      check($sformatf("tbl%0d_count", i),  32'(busy_count), 0);
`endif
      tick();
    end

    // Back-to-back issue: the older tag's broadcast must not clear entry 9.
    drive(1,9,4, 0,0,0, 9,0); tick();
    drive(1,9,5, 0,0,0, 9,0); tick();
    drive(0,0,0, 1,4,0, 9,0);
    check("b2b_busy_bcast", 32'(rd_busy_a), 1);
    check("b2b_tag_bcast",  32'(rd_tag_a), 5);
    tick();
    drive(0,0,0, 0,0,0, 9,0);
    check("b2b_busy_after", 32'(rd_busy_a), 1);
    check("b2b_tag_after",  32'(rd_tag_a), 5);
    tick();

    // Flush with a concurrent issue to 8: everything ends idle.
    drive(1,1,1, 0,0,0, 0,0); tick();
    drive(1,2,2, 0,0,0, 0,0); tick();
    drive(1,3,3, 0,0,0, 1,2);
    check("pre_flush_busy_a", 32'(rd_busy_a), 1);
    check("pre_flush_tag_b",  32'(rd_tag_b), 2);
    tick();
    drive(1,8,4, 0,0,1, 3,8); tick();
    drive(0,0,0, 0,0,0, 3,8);
    check("flush_busy_3", 32'(rd_busy_a), 0);
    check("flush_busy_8", 32'(rd_busy_b), 0);
    check("flush_count",  32'(busy_count), 0);
    tick();
    drive(0,0,0, 0,0,0, 1,2);
    check("flush_busy_1", 32'(rd_busy_a), 0);
    check("flush_busy_2", 32'(rd_busy_b), 0);
    tick();

    // Asynchronous reset between edges.
    drive(1,3,7, 1,20,0, 3,0); tick();
    #2;
    check("prerst_busy3", 32'(rd_busy_a), 1);
    check("prerst_event", 32'(cdb_event), 1);
    issue_valid = 1'b0; cdb_enable = 1'b0; cdb_tag = '0;
    rst_n = 1'b0;
    #1;
    check("arst_busy3", 32'(rd_busy_a), 0);
    check("arst_tag3",  32'(rd_tag_a), 0);
    check("arst_event", 32'(cdb_event), 0);
    check("arst_count", 32'(busy_count), 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomized traffic; small tag space and held enables exercise
    // multi-register clears, repeated tags and edge detection.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        r_en = int'(cdb_enable);
        r_ct = int'(cdb_tag);
      end else begin
        r_en = ($urandom_range(0, 9) < 6) ? 1 : 0;
        r_ct = int'($urandom_range(0, 7));
      end
      drive(int'($urandom_range(0, 1)), int'($urandom_range(0, NUM_REGS-1)),
            int'($urandom_range(0, 7)), r_en, r_ct,
            ($urandom_range(0, 39) == 0) ? 1 : 0,
            int'($urandom_range(0, NUM_REGS-1)), int'($urandom_range(0, NUM_REGS-1)));
      tick();
    end
    drive(0,0,0, 0,0,0, 0,0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
